regfile_scoreboard: RTL and testbench

Architectural register file and pending-write scoreboard that sits at the receiving end of the writeback stage's register-write interface. It commits `wb_regfile_*` writes, serves two combinational read ports with same-cycle write bypass, and tracks the number of in-flight writers per register. Decode uses the tracking to stall on RAW hazards and on scoreboard overflow.

---
 rtl/regfile_scoreboard_if.sv | 21 ++
 rtl/regfile_scoreboard.sv | 91 +++++++++
 tb/tb_regfile_scoreboard.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Writeback-to-register-file write bus.
// The complete stage drives it; the register file receives it.
interface regfile_scoreboard_if #(
    parameter int XLEN = 32
);
    logic            wb_regfile_en;
    logic [4:0]      wb_regfile_idx;
    logic [XLEN-1:0] wb_regfile_data;

    modport master (
        output wb_regfile_en,
        output wb_regfile_idx,
        output wb_regfile_data
    );

    modport slave (
        input wb_regfile_en,
        input wb_regfile_idx,
        input wb_regfile_data
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Architectural register file with a per-register pending-writer scoreboard.
// Two combinational read ports with optional same-cycle writeback bypass.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    regfile_scoreboard_if.slave  wb,
    input  logic                 claim_en,
    input  logic [4:0]           claim_idx,
    output logic                 claim_ok,
    input  logic                 flush,
    input  logic [4:0]           rd1_idx,
    input  logic [4:0]           rd2_idx,
    output logic [XLEN-1:0]      rd1_out,
    output logic [XLEN-1:0]      rd2_out,
    output logic                 rd1_busy,
    output logic                 rd2_busy
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [XLEN-1:0]  regs [1:31];
    logic [CNT_W-1:0] cnt  [1:31];

    logic wr_en;
    logic hit1;
    logic hit2;

    // Writes to x0 are dropped; x0 has no storage.
    assign wr_en = wb.wb_regfile_en & (wb.wb_regfile_idx != 5'd0);
    assign hit1  = BYPASS & wr_en & (wb.wb_regfile_idx == rd1_idx);
    assign hit2  = BYPASS & wr_en & (wb.wb_regfile_idx == rd2_idx);

    // Read port 1: x0 is zero, then bypass, then the array.
    always_comb begin
        rd1_out  = '0;
        rd1_busy = 1'b0;
        if (rd1_idx != 5'd0) begin
            rd1_out  = hit1 ? wb.wb_regfile_data : regs[rd1_idx];
            rd1_busy = cnt[rd1_idx] > (hit1 ? CNT_ONE : '0);
        end
    end

    // Read port 2: identical to port 1.
    always_comb begin
        rd2_out  = '0;
        rd2_busy = 1'b0;
        if (rd2_idx != 5'd0) begin
            rd2_out  = hit2 ? wb.wb_regfile_data : regs[rd2_idx];
            rd2_busy = cnt[rd2_idx] > (hit2 ? CNT_ONE : '0);
        end
    end

    // Accept a claim unless flushing or its counter is already full.
    always_comb begin
        claim_ok = claim_en & ~flush;
        if (claim_idx != 5'd0) begin
            claim_ok = claim_en & ~flush & (cnt[claim_idx] != CNT_MAX);
        end
    end

    // Register array: reset clears, else commit the writeback.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 1; r < 32; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_en) begin
            regs[wb.wb_regfile_idx] <= wb.wb_regfile_data;
        end
    end

    // Pending counters: claim increments, writeback decrements (floor 0).
    always_ff @(posedge clock) begin
        for (int r = 1; r < 32; r++) begin
            if (reset || flush) begin
                cnt[r] <= '0;
            end else if (claim_ok && claim_idx == 5'(r)) begin
                if (!(wr_en && wb.wb_regfile_idx == 5'(r))) begin
                    cnt[r] <= cnt[r] + CNT_ONE;
                end
            end else if (wr_en && wb.wb_regfile_idx == 5'(r)
                         && cnt[r] != '0) begin
                cnt[r] <= cnt[r] - CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard.
// Runs a bypass and a non-bypass instance on identical stimulus.
module tb_regfile_scoreboard;
    logic        clock;
    logic        reset;
    logic        claim_en;
    logic [4:0]  claim_idx;
    logic        flush;
    logic [4:0]  rd1_idx;
    logic [4:0]  rd2_idx;

    logic        b_claim_ok, n_claim_ok;
    logic [31:0] b_rd1_out, b_rd2_out, n_rd1_out, n_rd2_out;
    logic        b_rd1_busy, b_rd2_busy, n_rd1_busy, n_rd2_busy;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard_if #(.XLEN(32)) b_if ();
    regfile_scoreboard_if #(.XLEN(32)) n_if ();

    regfile_scoreboard #(.XLEN(32), .BYPASS(1'b1), .CNT_W(2)) u_b (
        .clock(clock), .reset(reset), .wb(b_if.slave),
        .claim_en(claim_en), .claim_idx(claim_idx), .claim_ok(b_claim_ok),
        .flush(flush), .rd1_idx(rd1_idx), .rd2_idx(rd2_idx),
        .rd1_out(b_rd1_out), .rd2_out(b_rd2_out),
        .rd1_busy(b_rd1_busy), .rd2_busy(b_rd2_busy)
    );

    regfile_scoreboard #(.XLEN(32), .BYPASS(1'b0), .CNT_W(2)) u_n (
        .clock(clock), .reset(reset), .wb(n_if.slave),
        .claim_en(claim_en), .claim_idx(claim_idx), .claim_ok(n_claim_ok),
        .flush(flush), .rd1_idx(rd1_idx), .rd2_idx(rd2_idx),
        .rd1_out(n_rd1_out), .rd2_out(n_rd2_out),
        .rd1_busy(n_rd1_busy), .rd2_busy(n_rd2_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wb_drive(input logic en, input logic [4:0] idx,
                            input logic [31:0] data);
        b_if.wb_regfile_en   = en;
        b_if.wb_regfile_idx  = idx;
        b_if.wb_regfile_data = data;
        n_if.wb_regfile_en   = en;
        n_if.wb_regfile_idx  = idx;
        n_if.wb_regfile_data = data;
    endtask

    initial begin
        reset = 1'b1;
        claim_en = 1'b0;
        claim_idx = '0;
        flush = 1'b0;
        rd1_idx = '0;
        rd2_idx = '0;
        wb_drive(1'b0, 5'd0, 32'h0);

        // reset; claims are accepted combinationally but discarded
        tick();
        tick();
        claim_en = 1'b1;
        claim_idx = 5'd5;
        #1;
        check("rst_claim_ok", b_claim_ok, 1'b1);
        tick();
        reset = 1'b0;
        claim_en = 1'b0;

        for (int i = 0; i < 32; i++) begin
            rd1_idx = 5'(i);
            rd2_idx = 5'(31 - i);
            #1;
            check("rst_rd1", b_rd1_out, 32'h0);
            check("rst_rd2", b_rd2_out, 32'h0);
            check("rst_busy1", b_rd1_busy, 1'b0);
            check("rst_busy2", b_rd2_busy, 1'b0);
            tick();
        end

        // write with and without bypass
        rd1_idx = 5'd3;
        wb_drive(1'b1, 5'd3, 32'hDEADBEEF);
        #1;
        check("byp_same", b_rd1_out, 32'hDEADBEEF);
        check("nobyp_same", n_rd1_out, 32'h0);
        tick();
        wb_drive(1'b0, 5'd0, 32'h0);
        #1;
        check("byp_next", b_rd1_out, 32'hDEADBEEF);
        check("nobyp_next", n_rd1_out, 32'hDEADBEEF);

        // x0 writes and claims
        tick();
        rd1_idx = 5'd0;
        rd2_idx = 5'd0;
        claim_en = 1'b1;
        claim_idx = 5'd0;
        wb_drive(1'b1, 5'd0, 32'h1234);
        #1;
        check("x0_rd1", b_rd1_out, 32'h0);
        check("x0_rd2", b_rd2_out, 32'h0);
        check("x0_busy", b_rd1_busy, 1'b0);
        check("x0_claim", b_claim_ok, 1'b1);
        tick();
        claim_en = 1'b0;
        wb_drive(1'b0, 5'd0, 32'h0);
        #1;
        check("x0_rd1_next", b_rd1_out, 32'h0);
        check("x0_busy_next", b_rd1_busy, 1'b0);

        // fill x7 to max
        rd2_idx = 5'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            claim_en = 1'b1;
            claim_idx = 5'd7;
            #1;
            check("x7_claim", b_claim_ok, 1'b1);
        end
        tick();
        #1;
        check("x7_full_ok", b_claim_ok, 1'b0);
        check("x7_busy", b_rd2_busy, 1'b1);
        tick();
        claim_en = 1'b0;

        // drain x7: bypass busy drops with the third writeback
        wb_drive(1'b1, 5'd7, 32'h77);
        #1;
        check("x7_wb1_busy", b_rd2_busy, 1'b1);
        tick();
        #1;
        check("x7_wb2_busy", b_rd2_busy, 1'b1);
        tick();
        #1;
        check("x7_wb3_busy", b_rd2_busy, 1'b0);
        check("x7_wb3_nbusy", n_rd2_busy, 1'b1);
        tick();
        wb_drive(1'b0, 5'd0, 32'h0);
        #1;
        check("x7_idle", b_rd2_busy, 1'b0);
        check("x7_nidle", n_rd2_busy, 1'b0);
        check("x7_data", b_rd2_out, 32'h77);

        // claim + writeback at count 1 keeps count 1
        claim_en = 1'b1;
        claim_idx = 5'd7;
        tick();
        wb_drive(1'b1, 5'd7, 32'h78);
        #1;
        check("x7_cw_ok", b_claim_ok, 1'b1);
        tick();
        claim_en = 1'b0;
        wb_drive(1'b0, 5'd0, 32'h0);
        #1;
        check("x7_cw_busy", b_rd2_busy, 1'b1);

        // claim + writeback at max: refused, count drops to 2
        claim_en = 1'b1;
        tick();
        tick();
        wb_drive(1'b1, 5'd7, 32'h79);
        #1;
        check("x7_max_cw_ok", b_claim_ok, 1'b0);
        tick();
        wb_drive(1'b0, 5'd0, 32'h0);
        #1;
        check("x7_retry_ok", b_claim_ok, 1'b1);
        tick();
        claim_en = 1'b0;
        wb_drive(1'b1, 5'd7, 32'h7A);
        tick();
        tick();
        tick();
        wb_drive(1'b0, 5'd0, 32'h0);
        #1;
        check("x7_drained", b_rd2_busy, 1'b0);

        // flush squashes pending and a same-cycle claim
        claim_en = 1'b1;
        claim_idx = 5'd9;
        tick();
        tick();
        flush = 1'b1;
        claim_idx = 5'd4;
        #1;
        check("flush_claim_ok", b_claim_ok, 1'b0);
        tick();
        flush = 1'b0;
        claim_en = 1'b0;
        rd1_idx = 5'd9;
        rd2_idx = 5'd4;
        #1;
        check("flush_x9_busy", b_rd1_busy, 1'b0);
        check("flush_x4_busy", b_rd2_busy, 1'b0);
        wb_drive(1'b1, 5'd9, 32'hA5A5A5A5);
        tick();
        wb_drive(1'b0, 5'd0, 32'h0);
        #1;
        check("strag_data", b_rd1_out, 32'hA5A5A5A5);
        check("strag_busy", b_rd1_busy, 1'b0);
        claim_en = 1'b1;
        claim_idx = 5'd9;
        #1;
        check("strag_claim", b_claim_ok, 1'b1);
        tick();
        claim_en = 1'b0;

        // reset beats a concurrent writeback
        rd1_idx = 5'd2;
        wb_drive(1'b1, 5'd2, 32'h55);
        tick();
        wb_drive(1'b0, 5'd0, 32'h0);
        claim_en = 1'b1;
        claim_idx = 5'd2;
        tick();
        claim_en = 1'b0;
        #1;
        check("mid_pre_data", b_rd1_out, 32'h55);
        check("mid_pre_busy", b_rd1_busy, 1'b1);
        tick();
        reset = 1'b1;
        wb_drive(1'b1, 5'd2, 32'h99);
        tick();
        reset = 1'b0;
        wb_drive(1'b0, 5'd0, 32'h0);
        rd2_idx = 5'd9;
        #1;
        check("mid_rd", b_rd1_out, 32'h0);
        check("mid_busy", b_rd1_busy, 1'b0);
        check("mid_nrd", n_rd1_out, 32'h0);
        check("mid_x9_rd", b_rd2_out, 32'h0);
        check("mid_x9_busy", b_rd2_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
